// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, index/word/function types and the output-stage fill state
package cpu_pkg;
  localparam int W = 18;
  localparam int RA = 3;
  localparam int FW = 4;
  typedef logic [RA-1:0] reg_idx_t;
  typedef logic [W-1:0] word_t;
  typedef logic [FW-1:0] funct_t;
  typedef enum logic {EMPTY, FULL} fill_t;
endpackage

// File: rtl/regfile2r1w.sv
// regfile2r1w: two combinational reads, one synchronous write, R0 hardwired to zero
module regfile2r1w #(
  parameter int W = cpu_pkg::W,
  parameter int RA = cpu_pkg::RA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RA-1:0] ra,
  input  logic [RA-1:0] rb,
  input  logic          we,
  input  logic [RA-1:0] wa,
  input  logic [W-1:0]  wd,
  output logic [W-1:0]  rda,
  output logic [W-1:0]  rdb
);
  logic [W-1:0] mem [2**RA];
  // write port; R0 is never written so its storage stays zero
  always_ff @(posedge clk or posedge reset)
    if (reset) mem <= '{default: '0};
    else if (we && wa != '0) mem[wa] <= wd;
  assign rda = ra == '0 ? '0 : mem[ra];
  assign rdb = rb == '0 ? '0 : mem[rb];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register read stage with RAW scoreboard and one-entry output register
// (OPERAND_FETCH_BYPASS_EN forwards same-cycle write-back data to the operand reads)
module operand_fetch #(
  parameter int W = cpu_pkg::W,
  parameter int RA = cpu_pkg::RA,
  parameter int FW = cpu_pkg::FW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RA-1:0] in_rs,
  input  logic [RA-1:0] in_rt,
  input  logic [RA-1:0] in_rd,
  input  logic [FW-1:0] in_f,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [FW-1:0] out_f,
  output logic [RA-1:0] out_rd,
  input  logic          wb_en,
  input  logic [RA-1:0] wb_addr,
  input  logic [W-1:0]  wb_data
);
  import cpu_pkg::*;
  fill_t state, state_nx;
  logic [2**RA-1:0] pend;
  logic [W-1:0] rf_a, rf_b, a, b;
  logic byp_rs, byp_rt, hz, accept;
  regfile2r1w #(.W(W), .RA(RA)) u_rf (
    .clk, .reset, .ra(in_rs), .rb(in_rt), .we(wb_en), .wa(wb_addr), .wd(wb_data),
    .rda(rf_a), .rdb(rf_b)
  );
`ifdef OPERAND_FETCH_BYPASS_EN
  assign byp_rs = wb_en && wb_addr == in_rs && in_rs != '0;
  assign byp_rt = wb_en && wb_addr == in_rt && in_rt != '0;
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif
  assign a = byp_rs ? wb_data : rf_a;
  assign b = byp_rt ? wb_data : rf_b;
  assign hz = (pend[in_rs] && in_rs != '0 && !byp_rs) || (pend[in_rt] && in_rt != '0 && !byp_rt);
  assign out_valid = state == FULL;
  assign in_ready = !hz && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  // fill state register: EMPTY/FULL mirrors out_valid
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nx;
  // a new accept keeps the stage full; a consume without refill empties it
  always_comb begin
    state_nx = accept ? FULL : out_ready ? EMPTY : state;
  end
  // output register loads only on accept, so it holds while execute stalls
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_a <= '0;
      out_b <= '0;
      out_f <= '0;
      out_rd <= '0;
    end else if (accept) begin
      out_a <= a;
      out_b <= b;
      out_f <= in_f;
      out_rd <= in_rd;
    end
  // scoreboard: write-back clears, issue sets; the later set wins on a same-register collision
  always_ff @(posedge clk or posedge reset)
    if (reset) pend <= '0;
    else begin
      if (wb_en) pend[wb_addr] <= 1'b0;
      if (accept && in_rd != '0) pend[in_rd] <= 1'b1;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against an array-based model
module tb_operand_fetch;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, wb_en = 0;
  logic [2:0] in_rs = 0, in_rt = 0, in_rd = 0, out_rd, wb_addr = 0;
  logic [3:0] in_f = 0, out_f;
  logic [17:0] out_a, out_b, wb_data = 0;
  int n_cmp = 0, n_bad = 0;
  logic [17:0] m_reg [8];
  bit m_pend [8];
  bit m_full;
  logic [17:0] m_a, m_b;
  logic [3:0] m_f;
  logic [2:0] m_rd;
  bit rdy;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_f(out_f), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 0;
    end
    m_full = 0; m_a = '0; m_b = '0; m_f = '0; m_rd = '0;
  endfunction

  function automatic bit fwd(int r);
    return BYP && r != 0 && wb_en && wb_addr == r;
  endfunction

  function automatic bit blocked(int r);
    return r != 0 && m_pend[r] && !fwd(r);
  endfunction

  function automatic logic [17:0] rd_val(int r);
    return r == 0 ? 18'h0 : fwd(r) ? wb_data : m_reg[r];
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input int rd, input int f,
                      input bit ordy, input bit we, input int wa, input logic [17:0] wd,
                      output bit got_ready);
    bit er, acc;
    @(negedge clk);
    in_valid = v; in_rs = 3'(rs); in_rt = 3'(rt); in_rd = 3'(rd); in_f = 4'(f);
    out_ready = ordy; wb_en = we; wb_addr = 3'(wa); wb_data = wd;
    #1;
    er = !blocked(rs) && !blocked(rt) && (!m_full || ordy);
    got_ready = in_ready;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_full);
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("out_f", out_f, m_f);
    check("out_rd", out_rd, m_rd);
    acc = v && er;
    if (acc) begin
      m_a = rd_val(rs); m_b = rd_val(rt); m_f = 4'(f); m_rd = 3'(rd); m_full = 1;
    end else if (ordy) m_full = 0;
    if (we && wa != 0) begin
      m_reg[wa] = wd;
      m_pend[wa] = 0;
    end
    if (acc && rd != 0) m_pend[rd] = 1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_a", out_a, 0);
    check("rst_rd", out_rd, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    // write R3, then read it
    step(0, 0, 0, 0, 0, 1, 1, 3, 18'h00ABC, rdy);
    step(1, 3, 0, 5, 7, 1, 0, 0, 0, rdy);
    after_edge();
    check("t1_valid", out_valid, 1);
    check("t1_a", out_a, 18'h00ABC);
    check("t1_b", out_b, 0);
    check("t1_rd", out_rd, 5);
    // dependent instruction on R5 stalls until write-back
    step(1, 5, 0, 1, 2, 1, 0, 0, 0, rdy);
    check("t2_stall", rdy, 0);
    step(1, 5, 0, 1, 2, 1, 1, 5, 18'h12345, rdy);
    check("t2_wb_cycle", rdy, BYP);
    if (!BYP) begin
      step(1, 5, 0, 1, 2, 1, 0, 0, 0, rdy);
      check("t2_late", rdy, 1);
    end
    after_edge();
    check("t2_a", out_a, 18'h12345);
    // output hold under backpressure
    step(1, 3, 3, 6, 9, 1, 0, 0, 0, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 4, 0, 0, 0, 0, rdy);
      check("t3_hold_ready", rdy, 0);
    end
    step(1, 0, 0, 0, 4, 1, 0, 0, 0, rdy);
    check("t3_release", rdy, 1);
    // issue and write-back to R2 in the same cycle: stays pending
    step(1, 0, 0, 2, 1, 1, 1, 2, 18'h00222, rdy);
    step(1, 2, 0, 0, 1, 1, 0, 0, 0, rdy);
    check("t4_pend2", rdy, 0);
    step(0, 0, 0, 0, 0, 1, 1, 2, 18'h00333, rdy);
    step(1, 2, 0, 0, 1, 1, 0, 0, 0, rdy);
    check("t4_clear", rdy, 1);
    after_edge();
    check("t4_a", out_a, 18'h00333);
    // writes to R0 are ignored; rd=0 never pends
    step(0, 0, 0, 0, 0, 1, 1, 0, 18'h3FFFF, rdy);
    step(1, 0, 0, 0, 3, 1, 0, 0, 0, rdy);
    after_edge();
    check("t5_r0", out_a, 0);
    // async reset drops the held entry and the scoreboard
    step(1, 0, 0, 4, 5, 1, 0, 0, 0, rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    @(negedge clk);
    out_ready = 0; in_valid = 0; wb_en = 0;
    #1;
    check("t6_pre_valid", out_valid, 1);
    reset = 1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_a", out_a, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    step(1, 4, 4, 0, 1, 1, 0, 0, 0, rdy);
    check("t6_no_stall", rdy, 1);
    after_edge();
    check("t6_r4", out_a, 0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int wa;
      wa = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, wa, 18'($urandom), rdy);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-file read stage that sits directly upstream of the R-type ALU, multdiv and shifter.
- Holds the architectural register file and reads two source operands per instruction.
- Tracks in-flight destinations with a scoreboard and stalls on RAW hazards.
- Presents operands, function code and destination to the execute stage through a one-entry valid/ready output register; write-back returns through a dedicated port.

Parameters:
- W, 18: datapath and register width in bits.
- RA, 3: register address width; the file holds 2**RA registers.
- FW, 4: function-code width, passed through unchanged to the ALU F input.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_rs  input  RA  source A register index.
- in_rt  input  RA  source B register index.
- in_rd  input  RA  destination index; 0 means no write.
- in_f  input  FW  function code.
- out_valid  output  1  operands valid toward execute.
- out_ready  input  1  execute consumes this cycle.
- out_a  output  W  operand A.
- out_b  output  W  operand B.
- out_f  output  FW  registered function code.
- out_rd  output  RA  registered destination index.
- wb_en  input  1  write-back strobe.
- wb_addr  input  RA  write-back register index.
- wb_data  input  W  write-back value.

Behaviour:
- Reset (async, active-high): all registers cleared to 0, scoreboard cleared, out_valid=0, out_a=out_b=0, out_f=0, out_rd=0. Reset asserted mid-operation drops the held entry and all pending bits.
- R0 is hardwired to 0: writes to it are ignored, it is never marked pending, and reads of it return 0.
- Write: on a clk edge with wb_en=1 and wb_addr≠0, reg[wb_addr] takes wb_data and pend[wb_addr] is cleared.
- Hazard: hz = (pend[in_rs] & in_rs≠0 & ~byp_rs) | (pend[in_rt] & in_rt≠0 & ~byp_rt). Here byp_x = wb_en & wb_addr==x, and bypass exists only when the optional feature is enabled.
- Handshake:
  - in_ready = ~hz & (~out_valid | out_ready). This is combinational, and in_ready must not depend on in_valid.
  - accept = in_valid & in_ready.
  - On accept, the output register loads the operands, in_f and in_rd, and out_valid becomes 1 on the next edge.
  - If out_valid & out_ready & ~accept, out_valid becomes 0.
  - The output holds stable while out_valid & ~out_ready.
- Latency is 1 cycle from accept to out_valid. Back-to-back throughput is 1 instruction per cycle when there are no hazards.
- Scoreboard: on accept with in_rd≠0, pend[in_rd] is set.
- Simultaneous events:
  - Issue and write-back to the same register in the same cycle: set wins and the register stays pending for the new producer. The write still updates reg.
  - Write-back to a non-pending register is legal and only updates the data.
- An instruction with in_rs==in_rd reads the old value and then marks the register pending.
- No internal state machine beyond the output-register valid bit and the scoreboard; the stage has two states, EMPTY and FULL, following out_valid.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined: write-back data is forwarded combinationally to an operand read in the same cycle when wb_en & wb_addr==source & source≠0. The pending check for that source is waived, so a dependent instruction issues in the write-back cycle.
- Undefined: no forwarding. A dependent instruction stalls until the edge after write-back and then reads the register file, which costs one extra cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams W=18, RA=3, FW=4.
  - typedef reg_idx_t (logic [RA-1:0]).
  - typedef word_t (logic [W-1:0]).
  - typedef funct_t (logic [FW-1:0]).
- One sub-module, regfile2r1w: 2 combinational reads, 1 synchronous write, R0 forced to zero. The scoreboard, bypass and handshake stay in operand_fetch.

Test Plan:
- Reset, then write R3=18'h00ABC via wb, then issue rs=3, rt=0, rd=5 -> next cycle out_valid=1, out_a=00ABC, out_b=0, and pend[5]=1.
- Issue rd=5, then immediately issue rs=5 -> in_ready=0 (stall). wb 5=18'h12345 -> with the macro defined, the dependent instruction is accepted the same cycle and out_a=12345; without the macro it is accepted one cycle later with out_a=12345.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_a/out_b/out_f/out_rd stay stable and in_ready=0; release -> the next instruction is accepted in the same cycle.
- Issue rd=2 and wb_addr=2 in the same cycle -> pend[2] stays 1 and reg[2] is updated; a second wb to 2 clears pend[2].
- wb_en=1, wb_addr=0, wb_data=3FFFF, then read rs=0 -> out_a=0; issue rd=0 -> no pending bit is set.
- Assert reset while out_valid=1 and pend[4]=1 -> out_valid=0 immediately (async) and all pending bits clear; after release an instruction reading R4 issues with no stall and returns 0.
